// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the pixel pipeline.
// The generator drives sync, blank and coordinates; the consumer drives enable.
interface vga_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          enable;
    logic          h_sync;
    logic          v_sync;
    logic          video_enable;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  enable,
        output h_sync, v_sync, video_enable, x, y, line_start, frame_start
    );

    modport slave (
        output enable,
        input  h_sync, v_sync, video_enable, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing: pixel/line counters, sync/blank decode,
// optional pixel clock divider, pause and a sync/blank alignment delay line.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int PIX_DIV  = 1,
    parameter int DELAY    = 0,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC - 1;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC - 1;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    // {h_sync, v_sync, video_enable} as seen while in reset
    localparam logic [2:0] SYNC_IDLE = {~H_POL, ~V_POL, 1'b0};

    logic [DW-1:0] div;
    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          tick, h_wrap, v_wrap;
    logic          active, hs, vs, line_go;

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          ls_q, fs_q;
    logic [2:0]    stage;
    logic [2:0]    sync_out;

    assign tick   = vga.enable && (div == DW'(PIX_DIV - 1));
    assign h_wrap = (h_cnt == XW'(H_TOTAL - 1));
    assign v_wrap = (v_cnt == YW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (vga.enable) begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
                // line-aligned vertical advance keeps v_sync edges on h wrap
                if (h_wrap)
                    v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end
        end
    end

    assign active  = (h_cnt < XW'(H_ACTIVE)) && (v_cnt < YW'(V_ACTIVE));
    assign hs      = (h_cnt >= XW'(HS_BEG)) && (h_cnt <= XW'(HS_END));
    assign vs      = (v_cnt >= YW'(VS_BEG)) && (v_cnt <= YW'(VS_END));
    assign line_go = vga.enable && (div == '0) && (h_cnt == '0);

    // Strobes follow enable every cycle; the rest freeze while paused.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q   <= '0;
            y_q   <= '0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
            stage <= SYNC_IDLE;
        end else begin
            ls_q <= line_go;
            fs_q <= line_go && (v_cnt == '0);
            if (vga.enable) begin
                x_q   <= h_cnt;
                y_q   <= v_cnt;
                stage <= {hs ? H_POL : ~H_POL, vs ? V_POL : ~V_POL, active};
            end
        end
    end

    generate
        if (DELAY == 0) begin : g_nodly
            assign sync_out = stage;
        end else begin : g_dly
            logic [DELAY-1:0][2:0] dly_pipe;

            // keeps shifting while paused so it settles onto the frozen stage
            always_ff @(posedge clk) begin
                if (!rst) begin
                    dly_pipe <= {DELAY{SYNC_IDLE}};
                end else begin
                    dly_pipe[0] <= stage;
                    for (int i = 1; i < DELAY; i++)
                        dly_pipe[i] <= dly_pipe[i-1];
                end
            end

            assign sync_out = dly_pipe[DELAY-1];
        end
    endgenerate

    assign {vga.h_sync, vga.v_sync, vga.video_enable} = sync_out;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: four raster configurations driven together, checked every cycle
// against a pixel-index reference model plus directed pause/reset checks.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.XW(10), .YW(10)) v_a ();
    vga_timing_gen_if #(.XW(10), .YW(10)) v_b ();
    vga_timing_gen_if #(.XW(10), .YW(10)) v_c ();
    vga_timing_gen_if #(.XW(10), .YW(10)) v_d ();

    assign v_a.enable = enable;
    assign v_b.enable = enable;
    assign v_c.enable = enable;
    assign v_d.enable = enable;

    // small raster, PIX_DIV=1, DELAY=0
    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1))
        u_a (.clk(clk), .rst(rst), .vga(v_a));
    // small raster, PIX_DIV=3
    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIX_DIV(3))
        u_b (.clk(clk), .rst(rst), .vga(v_b));
    // small raster, DELAY=3, positive sync
    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b1), .V_POL(1'b1), .DELAY(3))
        u_c (.clk(clk), .rst(rst), .vga(v_c));
    // 640x480 defaults
    vga_timing_gen u_d (.clk(clk), .rst(rst), .vga(v_d));

    localparam int NT = 4;
    localparam int HA[NT] = '{4, 4, 4, 640};
    localparam int HF[NT] = '{1, 1, 1, 16};
    localparam int HS[NT] = '{2, 2, 2, 96};
    localparam int HB[NT] = '{1, 1, 1, 48};
    localparam int VA[NT] = '{3, 3, 3, 480};
    localparam int VF[NT] = '{1, 1, 1, 10};
    localparam int VS[NT] = '{1, 1, 1, 2};
    localparam int VB[NT] = '{1, 1, 1, 33};
    localparam int PD[NT] = '{1, 3, 1, 1};
    localparam int DL[NT] = '{0, 0, 3, 0};
    localparam int HP[NT] = '{0, 0, 1, 0};
    localparam int VP[NT] = '{0, 0, 1, 0};

    // {x[24:15], y[14:5], h_sync[4], v_sync[3], video_enable[2], line_start[1], frame_start[0]}
    logic [24:0] obs [NT];
    assign obs[0] = {v_a.x, v_a.y, v_a.h_sync, v_a.v_sync, v_a.video_enable, v_a.line_start, v_a.frame_start};
    assign obs[1] = {v_b.x, v_b.y, v_b.h_sync, v_b.v_sync, v_b.video_enable, v_b.line_start, v_b.frame_start};
    assign obs[2] = {v_c.x, v_c.y, v_c.h_sync, v_c.v_sync, v_c.video_enable, v_c.line_start, v_c.frame_start};
    assign obs[3] = {v_d.x, v_d.y, v_d.h_sync, v_d.v_sync, v_d.video_enable, v_d.line_start, v_d.frame_start};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // model: sub-pixel phase and linear pixel index within the frame
    int         phase_m [NT];
    int         pix_m   [NT];
    int         ex      [NT];
    int         ey      [NT];
    logic       els     [NT];
    logic       efs     [NT];
    logic [2:0] hist    [NT][8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ht(input int d);
        return HA[d] + HF[d] + HS[d] + HB[d];
    endfunction

    function automatic int vt(input int d);
        return VA[d] + VF[d] + VS[d] + VB[d];
    endfunction

    function automatic logic [2:0] idle_of(input int d);
        return {HP[d] == 0, VP[d] == 0, 1'b0};
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic model_edge(input int d, input logic r, input logic en);
        int h, v, hsb, vsb;
        logic [2:0] nst;
        if (!r) begin
            phase_m[d] = 0;
            pix_m[d]   = 0;
            ex[d]      = 0;
            ey[d]      = 0;
            els[d]     = 1'b0;
            efs[d]     = 1'b0;
            for (int k = 0; k < 8; k++) hist[d][k] = idle_of(d);
            return;
        end
        h   = pix_m[d] % ht(d);
        v   = pix_m[d] / ht(d);
        hsb = HA[d] + HF[d];
        vsb = VA[d] + VF[d];
        els[d] = en && (phase_m[d] == 0) && (h == 0);
        efs[d] = els[d] && (v == 0);
        nst = hist[d][0];
        if (en) begin
            ex[d] = h;
            ey[d] = v;
            nst[2] = (h >= hsb && h < hsb + HS[d]) ? (HP[d] != 0) : (HP[d] == 0);
            nst[1] = (v >= vsb && v < vsb + VS[d]) ? (VP[d] != 0) : (VP[d] == 0);
            nst[0] = (h < HA[d]) && (v < VA[d]);
        end
        for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = nst;
        if (en) begin
            phase_m[d]++;
            if (phase_m[d] == PD[d]) begin
                phase_m[d] = 0;
                pix_m[d]   = (pix_m[d] + 1) % (ht(d) * vt(d));
            end
        end
    endtask

    task automatic cycle(input logic r, input logic en);
        logic [24:0] exp;
        rst    = r;
        enable = en;
        @(posedge clk);
        for (int d = 0; d < NT; d++) model_edge(d, r, en);
        #1;
        for (int d = 0; d < NT; d++) begin
            exp = {10'(ex[d]), 10'(ey[d]), hist[d][DL[d]], els[d], efs[d]};
            chk($sformatf("model_d%0d_c%0d", d, cyc), 32'(obs[d]), 32'(exp));
        end
        cyc++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_fs[$];
        int b_ls[$];
        int b_fs[$];
        int d_hs_lo, d_ve, k;
        bit found;

        // reset state
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("rst_a_hs", 32'(obs[0][4]), 1);
        chk("rst_a_vs", 32'(obs[0][3]), 1);
        chk("rst_a_ve", 32'(obs[0][2]), 0);
        chk("rst_c_hs", 32'(obs[2][4]), 0);
        chk("rst_c_vs", 32'(obs[2][3]), 0);
        chk("rst_c_xy", 32'(obs[2][24:5]), 0);

        // free run from release
        d_hs_lo = 0;
        d_ve    = 0;
        for (int n = 0; n < 1600; n++) begin
            cycle(1'b1, 1'b1);
            if (n == 0) begin
                chk("first_fs_a", 32'(obs[0][0]), 1);
                chk("first_ve_a", 32'(obs[0][2]), 1);
            end
            if (obs[0][0]) a_fs.push_back(n);
            if (obs[1][1]) b_ls.push_back(n);
            if (obs[1][0]) b_fs.push_back(n);
            if (n < 800) begin
                if (!obs[3][4]) d_hs_lo++;
                if (obs[3][2])  d_ve++;
            end
        end
        chk("a_fs0", 32'(qat(a_fs, 0)), 0);
        chk("a_fs1", 32'(qat(a_fs, 1)), 48);
        chk("a_fs2", 32'(qat(a_fs, 2)), 96);
        chk("b_ls_period", 32'(qat(b_ls, 1) - qat(b_ls, 0)), 24);
        chk("b_fs_period", 32'(qat(b_fs, 1) - qat(b_fs, 0)), 144);
        chk("d_hs_low_cnt", 32'(d_hs_lo), 96);
        chk("d_ve_line0", 32'(d_ve), 640);

        // pause at x=2 on line 1
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle(1'b1, 1'b1);
            if (ex[0] == 2 && ey[0] == 1) found = 1'b1;
        end
        chk("pause_seek", 32'(found), 1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0);
            chk("pause_x", 32'(obs[0][24:15]), 2);
            chk("pause_y", 32'(obs[0][14:5]), 1);
            chk("pause_strobe", 32'(obs[0][1:0]), 0);
        end
        cycle(1'b1, 1'b1);
        chk("resume_x", 32'(obs[0][24:15]), 3);
        k = 11;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle(1'b1, 1'b1);
            k++;
            if (obs[0][0]) found = 1'b1;
        end
        chk("fs_late_seen", 32'(found), 1);
        chk("fs_late", 32'(k), 48);

        // random enable with occasional reset
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0);

        // reset mid-frame at x=6, y=4
        found = 1'b0;
        for (int i = 0; i < 150 && !found; i++) begin
            cycle(1'b1, 1'b1);
            if (ex[0] == 6 && ey[0] == 4) found = 1'b1;
        end
        chk("mid_rst_seek", 32'(found), 1);
        cycle(1'b0, 1'b1);
        chk("mid_rst_c_hs", 32'(obs[2][4]), 0);
        chk("mid_rst_c_vs", 32'(obs[2][3]), 0);
        chk("mid_rst_c_ve", 32'(obs[2][2]), 0);
        chk("mid_rst_a_xy", 32'(obs[0][24:5]), 0);
        chk("mid_rst_c_xy", 32'(obs[2][24:5]), 0);
        cycle(1'b1, 1'b1);
        for (int d = 0; d < NT; d++)
            chk($sformatf("post_rst_fs_d%0d", d), 32'(obs[d][0]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
